// File: rtl/cpu_mem_sized_if.sv
// EX-to-MEM bundle for the sized MEM stage.
// slave is the stage itself, master is the EX/WB side.
interface cpu_mem_sized_if;
    logic        in_valid;
    logic [31:0] current_pc;
    logic        wb_mask;
    logic        mem_rd;
    logic        mem_wr;
    logic [1:0]  mem_size;
    logic        mem_unsigned;
    logic [1:0]  wb_sel;
    logic [31:0] store_data;
    logic [31:0] alu_result;
    logic        reg_write_en;
    logic [4:0]  reg_write_num;
    logic        stall;
    logic        reg_write_en_mem;
    logic [4:0]  reg_write_num_mem;
    logic [31:0] reg_write_data;
    logic [31:0] dm_read_data;
    logic        misalign_exc;
    logic [31:0] exc_addr;
    logic [4:0]  reg_write_num_realtime;

    modport slave (
        input  in_valid, current_pc, wb_mask, mem_rd, mem_wr,
        input  mem_size, mem_unsigned, wb_sel, store_data,
        input  alu_result, reg_write_en, reg_write_num,
        output stall, reg_write_en_mem, reg_write_num_mem,
        output reg_write_data, dm_read_data, misalign_exc,
        output exc_addr, reg_write_num_realtime
    );

    modport master (
        output in_valid, current_pc, wb_mask, mem_rd, mem_wr,
        output mem_size, mem_unsigned, wb_sel, store_data,
        output alu_result, reg_write_en, reg_write_num,
        input  stall, reg_write_en_mem, reg_write_num_mem,
        input  reg_write_data, dm_read_data, misalign_exc,
        input  exc_addr, reg_write_num_realtime
    );
endinterface

// File: rtl/cpu_mem_sized.sv
// MEM stage: sized loads/stores, misalignment exceptions,
// wait-state stalls and the EX->WB pipeline latch.
module cpu_mem_sized #(
    parameter int DEPTH_LOG2  = 8,
    parameter int WAIT_STATES = 0
) (
    input logic            clk,
    input logic            clr,
    cpu_mem_sized_if.slave bus
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam bit HAS_WAIT = (WAIT_STATES > 0);
    localparam logic [3:0] WS_LOAD =
        HAS_WAIT ? 4'(WAIT_STATES - 1) : 4'd0;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        rwe_q, rwe_d;
    logic [4:0]  num_q, num_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] dm_q, dm_d;
    logic        exc_q, exc_d;
    logic [31:0] eaddr_q, eaddr_d;

    logic [31:0] mem [DEPTH];

    logic [DEPTH_LOG2-1:0] idx;
    logic [1:0]  lane;
    logic        is_byte, is_half, is_word;
    logic        req, misaligned, acc, exc, stall, do_store;
    logic [31:0] rword, load_val, store_word;
    logic [7:0]  rbyte;
    logic [15:0] rhalf;

    assign idx  = bus.alu_result[DEPTH_LOG2+1:2];
    assign lane = bus.alu_result[1:0];
    assign rword = mem[idx];

    // Access classification and exception detection.
    always_comb begin
        is_byte    = (bus.mem_size == 2'b00);
        is_half    = (bus.mem_size == 2'b01);
        is_word    = bus.mem_size[1];
        misaligned = (is_half & lane[0]) |
                     (is_word & (lane != 2'b00));
        req = bus.in_valid & bus.wb_mask &
              (bus.mem_rd | bus.mem_wr);
        acc = req & ~misaligned;
        exc = req & misaligned;
    end

    // Lane select and extension for loads; lane merge for stores.
    always_comb begin
        rbyte      = rword[{lane, 3'b000} +: 8];
        rhalf      = lane[1] ? rword[31:16] : rword[15:0];
        load_val   = rword;
        store_word = rword;
        unique case (1'b1)
            is_byte: begin
                load_val = bus.mem_unsigned ? {24'd0, rbyte}
                         : {{24{rbyte[7]}}, rbyte};
                store_word[{lane, 3'b000} +: 8] = bus.store_data[7:0];
            end
            is_half: begin
                load_val = bus.mem_unsigned ? {16'd0, rhalf}
                         : {{16{rhalf[15]}}, rhalf};
                if (lane[1]) store_word[31:16] = bus.store_data[15:0];
                else         store_word[15:0]  = bus.store_data[15:0];
            end
            is_word: begin
                load_val   = rword;
                store_word = bus.store_data;
            end
            default: ;
        endcase
    end

    // Wait-state sequencing; reset releases stall at once.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        stall   = 1'b0;
        case (state_q)
            IDLE: begin
                if (acc && HAS_WAIT) begin
                    stall   = 1'b1;
                    state_d = BUSY;
                    cnt_d   = WS_LOAD;
                end
            end
            BUSY: begin
                if (cnt_q != 4'd0) begin
                    stall = 1'b1;
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (clr) stall = 1'b0;
    end

    assign do_store = acc & bus.mem_wr & ~stall & ~clr;

    // Next value of the EX->WB latch: bubble while stalled.
    always_comb begin
        rwe_d   = rwe_q;
        num_d   = num_q;
        wdata_d = wdata_q;
        dm_d    = dm_q;
        exc_d   = exc;
        eaddr_d = exc ? bus.alu_result : eaddr_q;
        if (stall) begin
            rwe_d = 1'b0;
            num_d = 5'd0;
        end else begin
            rwe_d = bus.in_valid & bus.reg_write_en & ~exc;
            num_d = bus.reg_write_num;
            dm_d  = load_val;
            case (bus.wb_sel)
                2'b00:   wdata_d = bus.alu_result;
                2'b01:   wdata_d = load_val;
                2'b10:   wdata_d = bus.current_pc + 32'd1;
                default: wdata_d = 32'd0;
            endcase
        end
    end

    // State, counter and pipeline latch registers.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            rwe_q   <= 1'b0;
            num_q   <= 5'd0;
            wdata_q <= 32'd0;
            dm_q    <= 32'd0;
            exc_q   <= 1'b0;
            eaddr_q <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rwe_q   <= rwe_d;
            num_q   <= num_d;
            wdata_q <= wdata_d;
            dm_q    <= dm_d;
            exc_q   <= exc_d;
            eaddr_q <= eaddr_d;
        end
    end

    // Data memory write on the completing cycle only.
    always_ff @(posedge clk) begin
        if (do_store) mem[idx] <= store_word;
    end

    assign bus.stall                  = stall;
    assign bus.reg_write_en_mem       = rwe_q;
    assign bus.reg_write_num_mem      = num_q;
    assign bus.reg_write_data         = wdata_q;
    assign bus.dm_read_data           = dm_q;
    assign bus.misalign_exc           = exc_q;
    assign bus.exc_addr               = eaddr_q;
    assign bus.reg_write_num_realtime = bus.reg_write_num;
endmodule

// File: tb/tb_cpu_mem_sized.sv
// Bench for cpu_mem_sized: one instance with no wait states,
// one with three, driven from shared inputs and a byte-level model.
module tb_cpu_mem_sized;
    logic clk = 1'b0;
    logic clr;
    always #5 clk = ~clk;

    logic        sel, valid, mask, rd, wr, uns, rwen;
    logic [1:0]  size, wbsel;
    logic [31:0] pc, sd, alu;
    logic [4:0]  num;

    cpu_mem_sized_if if0 ();
    cpu_mem_sized_if if3 ();

    assign if0.in_valid      = valid & ~sel;
    assign if3.in_valid      = valid & sel;
    assign if0.current_pc    = pc;
    assign if3.current_pc    = pc;
    assign if0.wb_mask       = mask;
    assign if3.wb_mask       = mask;
    assign if0.mem_rd        = rd;
    assign if3.mem_rd        = rd;
    assign if0.mem_wr        = wr;
    assign if3.mem_wr        = wr;
    assign if0.mem_size      = size;
    assign if3.mem_size      = size;
    assign if0.mem_unsigned  = uns;
    assign if3.mem_unsigned  = uns;
    assign if0.wb_sel        = wbsel;
    assign if3.wb_sel        = wbsel;
    assign if0.store_data    = sd;
    assign if3.store_data    = sd;
    assign if0.alu_result    = alu;
    assign if3.alu_result    = alu;
    assign if0.reg_write_en  = rwen;
    assign if3.reg_write_en  = rwen;
    assign if0.reg_write_num = num;
    assign if3.reg_write_num = num;

    cpu_mem_sized #(.DEPTH_LOG2(8), .WAIT_STATES(0)) u0 (
        .clk(clk), .clr(clr), .bus(if0)
    );
    cpu_mem_sized #(.DEPTH_LOG2(8), .WAIT_STATES(3)) u3 (
        .clk(clk), .clr(clr), .bus(if3)
    );

    int errors = 0;
    int checks = 0;
    logic [7:0]  bm [2][1024];
    logic [31:0] eaddr [2];

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int nbytes(input logic [1:0] sz);
        return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    endfunction

    // Little-endian byte gather with optional sign extension.
    function automatic logic [31:0] mload(input int s, input logic [31:0] a,
                                          input logic [1:0] sz, input logic u);
        int nb, b;
        logic [31:0] v;
        nb = nbytes(sz);
        b  = int'(a[9:0]);
        v  = 32'd0;
        for (int i = 0; i < nb; i++)
            v = v | (32'(bm[s][b+i]) << (8 * i));
        if (!u && nb < 4 && v[8*nb-1] === 1'b1)
            v = v | ~((32'd1 << (8 * nb)) - 32'd1);
        return v;
    endfunction

    // One instruction: drive, count stall cycles, check the latch.
    task automatic op(input logic s, input logic v, input logic m,
                      input logic r, input logic w, input logic [1:0] sz,
                      input logic u, input logic [1:0] ws,
                      input logic [31:0] a, input logic [31:0] d,
                      input logic [31:0] p, input logic e);
        logic req, mis, acc, erwe, st;
        logic [31:0] ld, ewd;
        int nst, b;
        sel = s; valid = v; mask = m; rd = r; wr = w; size = sz;
        uns = u; wbsel = ws; alu = a; sd = d; pc = p; rwen = e;
        num = 5'($urandom);
        req  = v & m & (r | w);
        mis  = (sz == 2'b01 && a[0]) || (sz[1] && a[1:0] != 2'b00);
        acc  = req & ~mis;
        ld   = mload(int'(s), a, sz, u);
        erwe = v & e & ~(req & mis);
        case (ws)
            2'b00:   ewd = a;
            2'b01:   ewd = ld;
            2'b10:   ewd = p + 32'd1;
            default: ewd = 32'd0;
        endcase
        nst = 0;
        #1;
        chk("num_realtime", 32'(s ? if3.reg_write_num_realtime
                                  : if0.reg_write_num_realtime), 32'(num));
        for (int i = 0; i < 20; i++) begin
            st = s ? if3.stall : if0.stall;
            @(posedge clk);
            @(negedge clk);
            if (!st) break;
            nst++;
            chk("bubble_rwe", 32'(s ? if3.reg_write_en_mem
                                    : if0.reg_write_en_mem), 32'd0);
            #1;
        end
        chk("stall_cycles", nst, (acc && s) ? 3 : 0);
        chk("rwe", 32'(s ? if3.reg_write_en_mem : if0.reg_write_en_mem),
            32'(erwe));
        if (erwe)
            chk("num", 32'(s ? if3.reg_write_num_mem : if0.reg_write_num_mem),
                32'(num));
        chk("exc", 32'(s ? if3.misalign_exc : if0.misalign_exc),
            32'(req & mis));
        if (req & mis) eaddr[s] = a;
        chk("exc_addr", s ? if3.exc_addr : if0.exc_addr, eaddr[s]);
        if (ws != 2'b01 || (r && !mis))
            chk("wdata", s ? if3.reg_write_data : if0.reg_write_data, ewd);
        if (r && !mis)
            chk("dm_data", s ? if3.dm_read_data : if0.dm_read_data, ld);
        if (acc && w) begin
            b = int'(a[9:0]);
            for (int i = 0; i < nbytes(sz); i++)
                bm[s][b+i] = d[8*i +: 8];
        end
    endtask

    initial begin
        clr = 1'b1; sel = 1'b0; valid = 1'b0; mask = 1'b0; rd = 1'b0;
        wr = 1'b0; size = 2'b00; uns = 1'b0; wbsel = 2'b00; pc = 32'd0;
        sd = 32'd0; alu = 32'd0; rwen = 1'b0; num = 5'd0;
        eaddr[0] = 32'd0; eaddr[1] = 32'd0;
        @(negedge clk); @(negedge clk);
        chk("rst_rwe0", 32'(if0.reg_write_en_mem), 32'd0);
        chk("rst_num0", 32'(if0.reg_write_num_mem), 32'd0);
        chk("rst_wd0", if0.reg_write_data, 32'd0);
        chk("rst_dm0", if0.dm_read_data, 32'd0);
        chk("rst_exc0", 32'(if0.misalign_exc), 32'd0);
        chk("rst_ea0", if0.exc_addr, 32'd0);
        chk("rst_wd3", if3.reg_write_data, 32'd0);
        chk("rst_stall3", 32'(if3.stall), 32'd0);
        clr = 1'b0;
        @(negedge clk);

        // No wait states: word, byte and half accesses.
        op(0, 1, 1, 0, 1, 2'b10, 0, 2'b00, 32'h10, 32'h8899AABB, 32'h100, 1);
        op(0, 1, 1, 1, 0, 2'b10, 0, 2'b01, 32'h10, 32'h0, 32'h101, 1);
        chk("lw_word", if0.reg_write_data, 32'h8899AABB);
        op(0, 1, 1, 0, 1, 2'b00, 0, 2'b00, 32'h11, 32'h0000007F, 32'h102, 0);
        op(0, 1, 1, 1, 0, 2'b10, 0, 2'b01, 32'h10, 32'h0, 32'h103, 1);
        chk("lw_after_sb", if0.reg_write_data, 32'h88997FBB);
        op(0, 1, 1, 1, 0, 2'b00, 0, 2'b01, 32'h13, 32'h0, 32'h104, 1);
        chk("lb", if0.reg_write_data, 32'hFFFFFF88);
        op(0, 1, 1, 1, 0, 2'b00, 1, 2'b01, 32'h13, 32'h0, 32'h105, 1);
        chk("lbu", if0.reg_write_data, 32'h00000088);
        op(0, 1, 1, 1, 0, 2'b01, 0, 2'b01, 32'h12, 32'h0, 32'h106, 1);
        chk("lh", if0.reg_write_data, 32'hFFFF8899);

        // Misaligned accesses.
        op(0, 1, 1, 1, 0, 2'b10, 0, 2'b01, 32'h12, 32'h0, 32'h107, 1);
        chk("mis_exc", 32'(if0.misalign_exc), 32'd1);
        chk("mis_addr", if0.exc_addr, 32'h12);
        chk("mis_rwe", 32'(if0.reg_write_en_mem), 32'd0);
        op(0, 1, 1, 0, 1, 2'b01, 0, 2'b00, 32'h11, 32'h0000DEAD, 32'h108, 1);
        op(0, 1, 1, 1, 0, 2'b10, 0, 2'b01, 32'h10, 32'h0, 32'h109, 1);
        chk("mis_sh_nowrite", if0.reg_write_data, 32'h88997FBB);
        chk("exc_pulse_end", 32'(if0.misalign_exc), 32'd0);

        // PC+1 wrap, masked store, invalid store.
        op(0, 1, 1, 0, 0, 2'b10, 0, 2'b10, 32'h10, 32'h0, 32'hFFFFFFFF, 1);
        chk("pc_wrap", if0.reg_write_data, 32'h0);
        op(0, 1, 0, 0, 1, 2'b10, 0, 2'b00, 32'h10, 32'h12345678, 32'h10A, 1);
        op(0, 0, 1, 0, 1, 2'b10, 0, 2'b00, 32'h10, 32'h12345678, 32'h10B, 1);
        op(0, 1, 1, 1, 0, 2'b10, 0, 2'b01, 32'h10, 32'h0, 32'h10C, 1);
        chk("mask_nowrite", if0.reg_write_data, 32'h88997FBB);

        // Three wait states.
        op(1, 1, 1, 0, 1, 2'b10, 0, 2'b00, 32'h20, 32'h0, 32'h200, 1);
        op(1, 1, 1, 0, 1, 2'b10, 0, 2'b00, 32'h24, 32'h8899AABB, 32'h201, 1);
        op(1, 1, 1, 1, 0, 2'b10, 0, 2'b01, 32'h24, 32'h0, 32'h202, 1);
        chk("ws3_lw", if3.reg_write_data, 32'h8899AABB);
        op(1, 1, 0, 0, 1, 2'b10, 0, 2'b00, 32'h24, 32'h55555555, 32'h203, 1);

        // Reset during the second stall cycle of a store.
        sel = 1'b1; valid = 1'b1; mask = 1'b1; rd = 1'b0; wr = 1'b1;
        size = 2'b10; alu = 32'h20; sd = 32'h1; wbsel = 2'b00; rwen = 1'b1;
        #1;
        chk("busy_stall1", 32'(if3.stall), 32'd1);
        @(posedge clk); @(negedge clk);
        #1;
        chk("busy_stall2", 32'(if3.stall), 32'd1);
        clr = 1'b1;
        #1;
        chk("clr_stall", 32'(if3.stall), 32'd0);
        chk("clr_rwe", 32'(if3.reg_write_en_mem), 32'd0);
        chk("clr_wd", if3.reg_write_data, 32'd0);
        chk("clr_dm", if3.dm_read_data, 32'd0);
        chk("clr_ea", if3.exc_addr, 32'd0);
        eaddr[0] = 32'd0; eaddr[1] = 32'd0;
        valid = 1'b0;
        @(posedge clk); @(negedge clk);
        clr = 1'b0;
        @(negedge clk);
        op(1, 1, 1, 1, 0, 2'b10, 0, 2'b01, 32'h20, 32'h0, 32'h204, 1);
        chk("clr_store_dropped", if3.reg_write_data, 32'h0);

        // Random traffic over a pre-initialised window.
        for (int s = 0; s < 2; s++)
            for (int i = 0; i < 16; i++)
                op(s[0], 1, 1, 0, 1, 2'b10, 0, 2'b00, 32'(32'h40 + 4 * i),
                   $urandom, 32'h300, 1);
        for (int i = 0; i < 80; i++)
            op((i % 4) == 3, $urandom_range(0, 7) != 0,
               $urandom_range(0, 5) != 0, 1'($urandom), $urandom_range(0, 2) == 0,
               2'($urandom), 1'($urandom), 2'($urandom),
               32'(32'h40 + $urandom_range(0, 63)), $urandom, $urandom,
               1'($urandom));
        valid = 1'b0;
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
